// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, FSM encoding and the cpu bus request payload.
package mmio_uart_tx_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BAUD_W = 16;
    localparam int unsigned BIT_W  = 3;

    // Register offsets selected by addr[0]
    localparam int unsigned UART_TXDATA = 0;
    localparam int unsigned UART_STATUS = 1;

    // STATUS bit indices
    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // One cpu data-bus request as seen by this block
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BUS_W-1:0]  wdata;
        logic              re;
        logic [BE_W-1:0]   we;
    } cpu_req_t;

    // Assemble the STATUS register word; unused upper bits read as zero
    function automatic logic [BUS_W-1:0] status_word(input logic full,
                                                     input logic empty,
                                                     input logic busy,
                                                     input logic ovf);
        logic [BUS_W-1:0] v;
        v           = '0;
        v[ST_FULL]  = full;
        v[ST_EMPTY] = empty;
        v[ST_BUSY]  = busy;
        v[ST_OVF]   = ovf;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO feeding the UART serialiser.
// Build option UART_TX_FIFO_EN: defined -> DEPTH-entry ring buffer (DEPTH a
// power of two, >= 2); undefined -> single holding register, DEPTH ignored.
// A push into a full FIFO is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    // Elaboration-time guard on the depth parameter
    if (DEPTH < 1) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be at least 1");
    end

`ifdef UART_TX_FIFO_EN

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_pow2
        $error("sync_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

`else

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = r_valid;
    assign o_empty   = ~r_valid;
    assign w_do_pop  = i_pop & r_valid;
    assign w_do_push = i_push & (~r_valid | w_do_pop);
    assign o_data    = r_data;

    // Holding-register occupancy; a refill on the pop edge keeps it valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (w_do_push) begin
            r_valid <= 1'b1;
        end else if (w_do_pop) begin
            r_valid <= 1'b0;
        end
    end

    // Holding-register payload
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_data <= i_data;
        end
    end

`endif

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the cpu data bus.
// TXDATA (offset 0) stores queue bytes; STATUS (offset 1) reports
// full/empty/busy/overflow, overflow cleared by writing 1 to bit 3.
// rdata is zero except on the cycle after a STATUS read, so it can be ORed
// with the ram read data. Build option UART_TX_FIFO_EN selects a FIFO of
// FIFO_DEPTH entries; without it a single holding register is used.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 30'h0400_0000,
    parameter int unsigned       CLK_DIV    = 16,
    parameter int unsigned       FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  wdata,
    input  logic              re,
    input  logic [BE_W-1:0]   we,
    output logic [BUS_W-1:0]  rdata,
    output logic              tx
);

    // Elaboration-time parameter guards
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("mmio_uart_tx: CLK_DIV must be in 2..65535");
    end
    if (BASE_ADDR[0] != 1'b0) begin : g_bad_base
        $error("mmio_uart_tx: BASE_ADDR must be even");
    end

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

    cpu_req_t          w_req;
    logic              w_sel;
    logic              w_push;
    logic              w_stat_wr;
    logic              w_ovf_set;
    logic              w_ovf_clr;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_fifo_data;
    logic [BUS_W-1:0]  w_status_word;
    logic              w_unused;

    tx_state_e         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_ovf;
    logic [BUS_W-1:0]  r_rdata;

    tx_state_e         w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_tx_nxt;
    logic              w_pop;
    logic              w_baud_done;

    // Bus decode: two consecutive word addresses starting at BASE_ADDR
    assign w_req     = '{addr: addr, wdata: wdata, re: re, we: we};
    assign w_sel     = (w_req.addr[ADDR_W-1:1] == BASE_ADDR[ADDR_W-1:1]);
    assign w_push    = w_sel & w_req.we[0] & (w_req.addr[0] == 1'(UART_TXDATA));
    assign w_stat_wr = w_sel & w_req.we[0] & (w_req.addr[0] == 1'(UART_STATUS));
    assign w_ovf_clr = w_stat_wr & w_req.wdata[ST_OVF];
    assign w_ovf_set = w_push & w_full & ~w_pop;

    // Only the low byte lane and byte-enable 0 are meaningful here
    assign w_unused = ^{w_req.wdata[BUS_W-1:DATA_W], w_req.we[BE_W-1:1]};

    assign w_status_word = status_word(w_full, w_empty, (r_state != S_IDLE), r_ovf);
    assign w_baud_done   = (r_baud == '0);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_req.wdata[DATA_W-1:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Serialiser next-state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_shift_nxt = w_fifo_data;
                    w_tx_nxt    = 1'b0;
                end
            end

            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = BAUD_RELOAD;
                    w_bit_nxt  = r_bit + BIT_W'(1);
                    if (r_bit == BIT_W'(DATA_W - 1)) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end

            S_STOP: begin
                if (w_baud_done) begin
                    if (!w_empty) begin
                        // Chain the next frame with no idle gap
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                        w_baud_nxt  = BAUD_RELOAD;
                        w_shift_nxt = w_fifo_data;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Serialiser state register; reset aborts any frame and idles the line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Sticky overflow: a dropped byte sets it, W1C clears it, set wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Read data: STATUS on the edge after a selected read, zero otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_sel && w_req.re && (w_req.addr[0] == 1'(UART_STATUS))) begin
            r_rdata <= w_status_word;
        end else begin
            r_rdata <= '0;
        end
    end

    assign rdata = r_rdata;
    assign tx    = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLK_DIV=4. The reference model
// tracks the byte queue and frame start times; the expected line level is
// derived from the frame start time and bit position arithmetic.
module tb_mmio_uart_tx;

    localparam logic [29:0] BASE  = 30'h0400_0000;
    localparam int          D     = 4;
    localparam int          FRAME = 10 * D;
`ifdef UART_TX_FIFO_EN
    localparam int          DEPTH = 8;
`else
    localparam int          DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        tx;

    int n_checks = 0;
    int n_errors = 0;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (D),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .re    (re),
        .we    (we),
        .rdata (rdata),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    int          m_cyc    = 0;
    bit          m_have   = 1'b0;
    int          m_fs     = 0;
    logic [7:0]  m_fb     = 8'h00;
    bit          m_ovf    = 1'b0;
    bit          m_busy   = 1'b0;
    logic        m_tx     = 1'b1;
    logic [31:0] m_rd     = 32'h0;
    int          m_frames = 0;

    always @(posedge clk) begin : model
        int sz;
        int k;
        bit sel;
        bit pop;
        bit push;
        bit set;
        m_cyc = m_cyc + 1;
        if (!rst_n) begin
            m_q.delete();
            m_have = 1'b0;
            m_ovf  = 1'b0;
            m_busy = 1'b0;
            m_tx   = 1'b1;
            m_rd   = 32'h0;
        end else begin
            sel = (addr[29:1] == BASE[29:1]);
            sz  = m_q.size();
            if (sel && re && addr[0])
                m_rd = {28'd0, m_ovf, m_busy, (sz == 0), (sz == DEPTH)};
            else
                m_rd = 32'h0;
            pop = (sz > 0) && (!m_have || m_cyc >= m_fs + FRAME);
            if (pop) begin
                m_fb     = m_q.pop_front();
                m_fs     = m_cyc;
                m_have   = 1'b1;
                m_frames = m_frames + 1;
            end
            push = sel && we[0] && !addr[0];
            set  = 1'b0;
            if (push) begin
                if (sz == DEPTH && !pop) set = 1'b1;
                else m_q.push_back(wdata[7:0]);
            end
            if (set) m_ovf = 1'b1;
            else if (sel && we[0] && addr[0] && wdata[3]) m_ovf = 1'b0;
            if (m_have && m_cyc < m_fs + FRAME) begin
                k      = (m_cyc - m_fs) / D;
                m_busy = 1'b1;
                if (k == 0) m_tx = 1'b0;
                else if (k <= 8) m_tx = m_fb[k-1];
                else m_tx = 1'b1;
            end else begin
                m_busy = 1'b0;
                m_tx   = 1'b1;
            end
        end
    end

    // Drive one bus cycle, then return at the following falling edge
    task automatic step(input logic [29:0] a, input logic [31:0] d,
                        input logic r, input logic [3:0] w);
        addr  = a;
        wdata = d;
        re    = r;
        we    = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(30'h0, 32'h0, 1'b0, 4'h0);
            n_checks++;
            if (tx !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_tx cyc%0d: got %b expected 1", i, tx);
            end
            n_checks++;
            if (rdata !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_rdata cyc%0d: got %h expected 0", i, rdata);
            end
        end
        rst_n = 1'b1;
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h2) begin
            n_errors++;
            $display("FAIL reset_status: got %h expected 00000002", rdata);
        end
        n_checks++;
        if (tx !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_tx_after: got %b expected 1", tx);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       exp;
        b = 8'h55;
        step(BASE, 32'h0000_0055, 1'b0, 4'h1);
        n_checks++;
        if (tx !== 1'b1) begin
            n_errors++;
            $display("FAIL single_tx_at_push: got %b expected 1", tx);
        end
        for (int c = 1; c <= 40; c++) begin
            step(30'h0, 32'h0, 1'b0, 4'h0);
            if (c < 5) exp = 1'b0;
            else if (c < 37) exp = b[(c - 5) / D];
            else exp = 1'b1;
            n_checks++;
            if (tx !== exp || tx !== m_tx) begin
                n_errors++;
                $display("FAIL single_tx N+%0d: got %b expected %b (model %b)", c, tx, exp, m_tx);
            end
        end
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h6 || rdata !== m_rd) begin
            n_errors++;
            $display("FAIL single_status_stop: got %h expected 00000006", rdata);
        end
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h2 || rdata !== m_rd) begin
            n_errors++;
            $display("FAIL single_status_idle: got %h expected 00000002", rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        logic       trace[$];
        logic [7:0] b;
        int         i;
        int         nb;
        int         last;
        int         guard;
        for (int n = 0; n < DEPTH + 2; n++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            step(BASE, {24'($urandom), b}, 1'b0, 4'h1);
            trace.push_back(tx);
            n_checks++;
            if (tx !== m_tx) begin
                n_errors++;
                $display("FAIL b2b_tx_push%0d: got %b expected %b", n, tx, m_tx);
            end
        end
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        trace.push_back(tx);
        n_checks++;
        if (rdata !== 32'hD || rdata !== m_rd) begin
            n_errors++;
            $display("FAIL b2b_status_full: got %h expected 0000000d", rdata);
        end
        guard = 0;
        while (m_busy && guard < 2000) begin
            step(30'h0, 32'h0, 1'b0, 4'h0);
            trace.push_back(tx);
            guard++;
            n_checks++;
            if (tx !== m_tx) begin
                n_errors++;
                $display("FAIL b2b_tx cyc%0d: got %b expected %b", guard, tx, m_tx);
            end
        end
        n_checks++;
        if (guard >= 2000) begin
            n_errors++;
            $display("FAIL b2b_drain_timeout: got %0d cycles expected under 2000", guard);
        end
        // Decode the recorded line as a UART receiver would
        i = 0;
        nb = 0;
        last = -1;
        while (i + FRAME <= trace.size()) begin
            if (trace[i] == 1'b0) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++) b[k] = trace[i + D * (k + 1) + D / 2];
                n_checks++;
                if (nb > DEPTH || b !== bytes[nb]) begin
                    n_errors++;
                    $display("FAIL b2b_rx_byte%0d: got %h expected %h", nb, b,
                             (nb <= DEPTH) ? bytes[nb] : 8'hxx);
                end
                n_checks++;
                if (trace[i + 9 * D + D / 2] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_rx_stop%0d: got %b expected 1", nb, trace[i + 9 * D + D / 2]);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (i - last != FRAME) begin
                        n_errors++;
                        $display("FAIL b2b_gap%0d: got %0d expected %0d", nb, i - last, FRAME);
                    end
                end
                last = i;
                nb++;
                i = i + FRAME;
            end else begin
                i++;
            end
        end
        n_checks++;
        if (nb != DEPTH + 1) begin
            n_errors++;
            $display("FAIL b2b_frames: got %0d expected %0d", nb, DEPTH + 1);
        end
        // Writing STATUS without bit 3 must leave overflow set
        step(BASE + 30'd1, 32'h7, 1'b0, 4'h1);
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'hA || rdata !== m_rd) begin
            n_errors++;
            $display("FAIL b2b_ovf_kept: got %h expected 0000000a", rdata);
        end
        step(BASE + 30'd1, 32'h8, 1'b0, 4'h1);
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h2 || rdata !== m_rd) begin
            n_errors++;
            $display("FAIL b2b_w1c: got %h expected 00000002", rdata);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int n = 0; n < 3; n++) step(BASE, 32'($urandom), 1'b0, 4'h1);
        // First frame started one edge after the first push; land in DATA bit 3
        for (int c = 0; c < 15; c++) step(30'h0, 32'h0, 1'b0, 4'h0);
        rst_n = 1'b0;
        step(30'h0, 32'h0, 1'b0, 4'h0);
        n_checks++;
        if (tx !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_tx: got %b expected 1", tx);
        end
        rst_n = 1'b1;
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h2 || rdata !== m_rd) begin
            n_errors++;
            $display("FAIL midrst_status: got %h expected 00000002", rdata);
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            step(30'h0, 32'h0, 1'b0, 4'h0);
            n_checks++;
            if (tx !== 1'b1) begin
                n_errors++;
                $display("FAIL midrst_idle cyc%0d: got %b expected 1", c, tx);
            end
        end
    endtask

    task automatic test_negative();
        step(BASE, 32'h0000_00A5, 1'b0, 4'b0010);
        step(BASE + 30'd2, 32'h0000_005A, 1'b0, 4'hF);
        step(BASE + 30'd2, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL neg_read_out_of_range: got %h expected 0", rdata);
        end
        step(BASE, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL neg_read_txdata: got %h expected 0", rdata);
        end
        step(BASE + 30'd1, 32'h0, 1'b1, 4'h0);
        n_checks++;
        if (rdata !== 32'h2 || rdata !== m_rd) begin
            n_errors++;
            $display("FAIL neg_status: got %h expected 00000002", rdata);
        end
        n_checks++;
        if (tx !== 1'b1) begin
            n_errors++;
            $display("FAIL neg_tx: got %b expected 1", tx);
        end
    endtask

    task automatic test_random();
        logic [29:0] a;
        int          sel;
        for (int c = 0; c < 1500; c++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) a = BASE;
            else if (sel < 7) a = BASE + 30'd1;
            else if (sel == 7) a = BASE + 30'd2;
            else a = 30'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            step(a, $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
            n_checks++;
            if (tx !== m_tx) begin
                n_errors++;
                $display("FAIL rand_tx cyc%0d: got %b expected %b", c, tx, m_tx);
            end
            n_checks++;
            if (rdata !== m_rd) begin
                n_errors++;
                $display("FAIL rand_rdata cyc%0d: got %h expected %h", c, rdata, m_rd);
            end
        end
        rst_n = 1'b1;
        step(30'h0, 32'h0, 1'b0, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 30'h0;
        wdata = 32'h0;
        re    = 1'b0;
        we    = 4'h0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_negative();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
